// File: rtl/sdram_write_fifo_if.sv
// sdram_write_fifo_if: bus-side push / controller-side pop handshake bundle for the SDRAM write FIFO.
// Byte-enable signals exist only when SDRAM_WFIFO_BYTE_EN_EN is defined.
interface sdram_write_fifo_if #(parameter int ADDR_WIDTH = 9);
    logic                clearWriteFifo;
    logic                writePush;
    logic [31:0]         writeDataIn;
    logic                writeFull;
    logic                writeAlmostFull;
    logic                writePop;
    logic                writeEmpty;
    logic [31:0]         writeDataOut;
    logic                writeDataValid;
    logic [ADDR_WIDTH:0] fillLevel;
    logic                burstAvailable;
`ifdef SDRAM_WFIFO_BYTE_EN_EN
    logic [3:0]          writeByteEnIn;
    logic [3:0]          writeByteEnOut;
    modport slave (
        input  clearWriteFifo, writePush, writeDataIn, writeByteEnIn, writePop,
        output writeFull, writeAlmostFull, writeEmpty, writeDataOut, writeByteEnOut,
               writeDataValid, fillLevel, burstAvailable
    );
    modport master (
        output clearWriteFifo, writePush, writeDataIn, writeByteEnIn, writePop,
        input  writeFull, writeAlmostFull, writeEmpty, writeDataOut, writeByteEnOut,
               writeDataValid, fillLevel, burstAvailable
    );
`else
    modport slave (
        input  clearWriteFifo, writePush, writeDataIn, writePop,
        output writeFull, writeAlmostFull, writeEmpty, writeDataOut,
               writeDataValid, fillLevel, burstAvailable
    );
    modport master (
        output clearWriteFifo, writePush, writeDataIn, writePop,
        input  writeFull, writeAlmostFull, writeEmpty, writeDataOut,
               writeDataValid, fillLevel, burstAvailable
    );
`endif
endinterface

// File: rtl/sdram_write_fifo.sv
// sdram_write_fifo: bus-to-SDRAM write-data buffer with burst-ready flag and registered pop data.
// Optional SDRAM_WFIFO_BYTE_EN_EN stores per-word byte enables alongside the data.
module sdram_write_fifo #(
    parameter int ADDR_WIDTH         = 9,
    parameter int BURST_LENGTH       = 8,
    parameter int ALMOST_FULL_MARGIN = 4
) (
    input logic                clock,
    input logic                reset,
    sdram_write_fifo_if.slave  bus
);
`ifdef SDRAM_WFIFO_BYTE_EN_EN
    localparam int WIDTH = 36;
`else
    localparam int WIDTH = 32;
`endif
    localparam logic [ADDR_WIDTH:0] depth       = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] almostLevel = (ADDR_WIDTH+1)'(2**ADDR_WIDTH - ALMOST_FULL_MARGIN);
    localparam logic [ADDR_WIDTH:0] burstLevel  = (ADDR_WIDTH+1)'(BURST_LENGTH);

    logic [WIDTH-1:0]      mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] pushPtr, popPtr;
    logic [ADDR_WIDTH:0]   level, nextLevel;
    logic                  full, empty, almostFull, burst, valid;
    logic [31:0]           dataOut;
    logic                  doPush, doPop;
    logic [WIDTH-1:0]      pushWord, readWord;
`ifdef SDRAM_WFIFO_BYTE_EN_EN
    logic [3:0]            byteEnOut;
    assign pushWord           = {bus.writeByteEnIn, bus.writeDataIn};
    assign bus.writeByteEnOut = byteEnOut;
`else
    assign pushWord = bus.writeDataIn;
`endif

    // Flags come from the registered level, so a full FIFO ignores pushes and an empty one ignores pops.
    always_comb begin
        doPush    = bus.writePush & ~full;
        doPop     = bus.writePop & ~empty;
        readWord  = mem[popPtr];
        nextLevel = (doPush & ~doPop) ? level + 1'b1 :
                    (doPop & ~doPush) ? level - 1'b1 : level;
    end

    always_ff @(posedge clock)
        if (doPush & ~bus.clearWriteFifo)
            mem[pushPtr] <= pushWord;

    always_ff @(posedge clock or posedge reset) begin
        if (reset || bus.clearWriteFifo) begin
            pushPtr    <= '0;
            popPtr     <= '0;
            level      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            almostFull <= 1'b0;
            burst      <= 1'b0;
            valid      <= 1'b0;
            dataOut    <= '0;
`ifdef SDRAM_WFIFO_BYTE_EN_EN
            byteEnOut  <= '0;
`endif
        end else begin
            if (doPush)
                pushPtr <= pushPtr + 1'b1;
            if (doPop) begin
                popPtr  <= popPtr + 1'b1;
                dataOut <= readWord[31:0];
`ifdef SDRAM_WFIFO_BYTE_EN_EN
                byteEnOut <= readWord[35:32];
`endif
            end
            valid      <= doPop;
            level      <= nextLevel;
            empty      <= nextLevel == '0;
            full       <= nextLevel == depth;
            almostFull <= nextLevel >= almostLevel;
            burst      <= nextLevel >= burstLevel;
        end
    end

    assign bus.writeFull       = full;
    assign bus.writeEmpty      = empty;
    assign bus.writeAlmostFull = almostFull;
    assign bus.burstAvailable  = burst;
    assign bus.writeDataValid  = valid;
    assign bus.writeDataOut    = dataOut;
    assign bus.fillLevel       = level;
endmodule

// File: tb/tb_sdram_write_fifo.sv
// tb_sdram_write_fifo: directed and random stimulus against a queue-based reference of the write FIFO.
module tb_sdram_write_fifo;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    sdram_write_fifo_if #(.ADDR_WIDTH(AW)) bus ();
    sdram_write_fifo #(.ADDR_WIDTH(AW), .BURST_LENGTH(8), .ALMOST_FULL_MARGIN(4)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [35:0] q[$];
    logic [31:0] expData  = '0;
    logic [3:0]  expBe    = '0;
    logic        expValid = 1'b0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        int lvl;
        lvl = q.size();
        checkVal({tag, " level"}, 32'(bus.fillLevel), lvl);
        checkVal({tag, " empty"}, 32'(bus.writeEmpty), 32'(lvl == 0));
        checkVal({tag, " full"}, 32'(bus.writeFull), 32'(lvl == DEPTH));
        checkVal({tag, " almostFull"}, 32'(bus.writeAlmostFull), 32'(DEPTH - lvl <= 4));
        checkVal({tag, " burst"}, 32'(bus.burstAvailable), 32'(lvl >= 8));
        checkVal({tag, " valid"}, 32'(bus.writeDataValid), 32'(expValid));
        checkVal({tag, " data"}, bus.writeDataOut, expData);
`ifdef SDRAM_WFIFO_BYTE_EN_EN
        checkVal({tag, " byteEn"}, 32'(bus.writeByteEnOut), 32'(expBe));
`endif
    endtask

    task automatic cycle(input string tag, input logic p, input logic po, input logic [31:0] d,
                         input logic [3:0] be, input logic clr);
        bit          doPush, doPop;
        logic [35:0] w;
        @(negedge clock);
        bus.writePush      = p;
        bus.writePop       = po;
        bus.writeDataIn    = d;
        bus.clearWriteFifo = clr;
`ifdef SDRAM_WFIFO_BYTE_EN_EN
        bus.writeByteEnIn  = be;
`endif
        doPush = p && q.size() < DEPTH;
        doPop  = po && q.size() > 0;
        @(posedge clock);
        #1;
        if (clr) begin
            q.delete();
            expValid = 1'b0;
            expData  = '0;
            expBe    = '0;
        end else begin
            expValid = doPop;
            if (doPop) begin
                w       = q.pop_front();
                expData = w[31:0];
                expBe   = w[35:32];
            end
            if (doPush)
                q.push_back({be, d});
        end
        checkAll(tag);
    endtask

    task automatic asyncReset(input string tag);
        @(negedge clock);
        bus.writePush = 1'b1;
        #2 reset = 1'b1;
        #1;
        q.delete();
        expValid = 1'b0;
        expData  = '0;
        expBe    = '0;
        checkAll(tag);
        reset = 1'b0;
        bus.writePush = 1'b0;
    endtask

    initial begin
        bus.writePush      = 1'b0;
        bus.writePop       = 1'b0;
        bus.writeDataIn    = '0;
        bus.clearWriteFifo = 1'b0;
`ifdef SDRAM_WFIFO_BYTE_EN_EN
        bus.writeByteEnIn  = '0;
`endif
        #2 reset = 1'b1;
        #1 checkAll("reset");
        @(negedge clock);
        reset = 1'b0;

        for (int i = 1; i <= 8; i++) begin
            cycle("t1 push", 1, 0, 32'h11111111 * i, 4'(i), 0);
        end
        checkVal("t1 burstAfter8", 32'(bus.burstAvailable), 32'd1);
        for (int i = 1; i <= 8; i++) cycle("t1 pop", 0, 1, '0, '0, 0);
        checkVal("t1 emptyEnd", 32'(bus.writeEmpty), 32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            cycle("t2 push", 1, 0, $urandom, 4'($urandom), 0);
            if (i == 506) checkVal("t2 almost507", 32'(bus.writeAlmostFull), 32'd0);
            if (i == 507) checkVal("t2 almost508", 32'(bus.writeAlmostFull), 32'd1);
        end
        checkVal("t2 full", 32'(bus.writeFull), 32'd1);
        cycle("t2 push513", 1, 0, 32'hDEADBEEF, 4'hF, 0);
        checkVal("t2 level513", 32'(bus.fillLevel), 32'd512);
        for (int i = 0; i < DEPTH; i++) cycle("t2 pop", 0, 1, '0, '0, 0);
        cycle("t2 popEmpty", 0, 1, '0, '0, 0);
        checkVal("t2 noValid", 32'(bus.writeDataValid), 32'd0);

        for (int i = 0; i < 5; i++) cycle("t3 fill", 1, 0, $urandom, 4'($urandom), 0);
        for (int i = 0; i < 600; i++) cycle("t3 both", 1, 1, $urandom, 4'($urandom), 0);
        checkVal("t3 level5", 32'(bus.fillLevel), 32'd5);
        for (int i = 0; i < 5; i++) cycle("t3 drain", 0, 1, '0, '0, 0);

        cycle("t4 both", 1, 1, 32'hCAFEF00D, 4'h3, 0);
        checkVal("t4 noValid", 32'(bus.writeDataValid), 32'd0);
        checkVal("t4 level1", 32'(bus.fillLevel), 32'd1);
        cycle("t4 pop", 0, 1, '0, '0, 0);
        checkVal("t4 data", bus.writeDataOut, 32'hCAFEF00D);

        for (int i = 0; i < 300; i++) cycle("t5 fill", 1, 0, $urandom, 4'($urandom), 0);
        cycle("t5 clear", 1, 0, 32'h12345678, 4'hF, 1);
        checkVal("t5 clearLevel", 32'(bus.fillLevel), 32'd0);
        for (int i = 0; i < 300; i++) cycle("t5 refill", 1, 0, $urandom, 4'($urandom), 0);
        asyncReset("t5 areset");
        checkVal("t5 aresetEmpty", 32'(bus.writeEmpty), 32'd1);

        cycle("t6 push", 1, 0, 32'hA5A5A5A5, 4'b0101, 0);
        cycle("t6 push", 1, 0, 32'h5A5A5A5A, 4'b1000, 0);
        cycle("t6 pop", 0, 1, '0, '0, 0);
        checkVal("t6 data0", bus.writeDataOut, 32'hA5A5A5A5);
        cycle("t6 pop", 0, 1, '0, '0, 0);
        checkVal("t6 data1", bus.writeDataOut, 32'h5A5A5A5A);

        for (int i = 0; i < 3000; i++) begin
            cycle("rand", ($urandom % 8) < ((i / 500) % 2 ? 3 : 5), ($urandom % 8) < ((i / 500) % 2 ? 5 : 3),
                  $urandom, 4'($urandom), ($urandom % 200) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
